pipe_ctrl_stage_reg: RTL and testbench
======================================

// Module: pipe_ctrl_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register for the pipelined ARM core; generalises fixed E->M control flops.
//  Carries a CTRL_W-bit control bundle and a DATA_W-bit datapath bundle through STAGES back-to-back register slots.
//  Each slot has a valid bit; supports stall (hold), flush (bubble insertion) and a saturating killed-instruction counter.
// PARAMETERS
//  CTRL_W  4   width of control bundle (e.g. {PCSrc,RegWrite,MemtoReg,MemWrite}); zeroed on bubble/flush
//  DATA_W  32  width of datapath bundle (ALU result, write data, ...); never cleared except by reset
//  STAGES  1   number of register slots in series, legal 1..4
//  CNT_W   8   width of kill counter
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       asynchronous, active-low reset
//  stall      in   1       hold all slots this cycle
//  flush      in   1       invalidate all slots this cycle
//  valid_in   in   1       upstream slot holds a real instruction
//  ctrl_in    in   CTRL_W  upstream control bundle
//  data_in    in   DATA_W  upstream datapath bundle
//  valid_out  out  1       last slot valid
//  ctrl_out   out  CTRL_W  last slot control; all-zero whenever valid_out=0
//  data_out   out  DATA_W  last slot datapath bundle
//  kill_cnt   out  CNT_W   count of valid instructions discarded by flush
//  cnt_clr    in   1       synchronous clear of kill_cnt
// BEHAVIOUR
//  Reset (reset_n=0, async): all slot valid=0, ctrl=0, data=0, kill_cnt=0; outputs reflect immediately.
//  Latency: STAGES cycles from input to output when never stalled/flushed.
//  Normal (stall=0, flush=0): slot0 <= {valid_in, valid_in ? ctrl_in : 0, data_in}; slot[i] <= slot[i-1].
//  Stall only: every slot holds valid/ctrl/data; inputs ignored; kill_cnt unchanged.
//  Flush (any stall value): every slot valid<=0, ctrl<=0; data fields load as in normal shift (don't-care).
//   flush has priority over stall; in-flight input is also killed (slot0 gets valid=0).
//  Kill counter: on flush edge, kill_cnt += popcount(slot valids before edge) + valid_in; saturates at 2^CNT_W-1, no wrap.
//   cnt_clr=1 sets kill_cnt to 0 that edge; if flush in same cycle, clear wins, then new kills NOT added.
//  Invariant: any slot with valid=0 holds ctrl=0 (so a bubble never writes regfile/memory or redirects PC).
//  STAGES=1: single slot, behaviour identical to a stall/flush-capable E->M register.
//  Reset mid-operation: all pending contents lost; first post-reset edge behaves as normal shift.
//  No combinational path from any input to any output.
// TESTING
//  T1 CTRL_W=4,STAGES=1: valid_in=1, ctrl_in=4'b1011, data_in=32'hDEADBEEF -> next edge valid_out=1, ctrl_out=4'b1011, data_out=32'hDEADBEEF.
//  T2 STAGES=3: inject ctrl 1,2,3 on consecutive cycles -> appear at ctrl_out on cycles 3,4,5; stall at cycle 4 -> ctrl_out=2 held 2 cycles.
//  T3 STAGES=3 all slots valid, valid_in=1, flush=1 -> next edge all valid=0, ctrl_out=0, kill_cnt=4.
//  T4 flush=1 and stall=1 together with 2 valid slots -> slots cleared (flush wins), kill_cnt +=2 (+1 if valid_in).
//  T5 CNT_W=3, kill_cnt=6, flush with 3 valid -> kill_cnt=7 (saturate); cnt_clr=1 with flush -> kill_cnt=0.
//  T6 assert reset_n=0 mid-stream between edges -> outputs zero immediately; deassert -> pipeline refills from valid_in.

Source files
------------

// File: rtl/pipe_ctrl_stage_reg.sv
// Inter-stage pipeline register: STAGES slots of {valid, ctrl, data} with stall, flush
// and a saturating count of valid instructions discarded by flush.
module pipe_ctrl_stage_reg #(
  parameter int unsigned CTRL_W = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [CTRL_W-1:0] ctrl_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              cnt_clr,
  output logic              valid_out,
  output logic [CTRL_W-1:0] ctrl_out,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  kill_cnt
);

  // Up to STAGES (<=4) slot valids plus valid_in can be killed in one edge.
  localparam int unsigned KillW = 3;
  localparam int unsigned SumW  = CNT_W + KillW;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]              kill_q, kill_d;

  logic [KillW-1:0] kills;
  logic [SumW-1:0]  kill_sum;

  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush || !stall) begin
      valid_d[0] = valid_in;
      ctrl_d[0]  = valid_in ? ctrl_in : '0;
      data_d[0]  = data_in;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1];
        ctrl_d[i]  = ctrl_q[i-1];
        data_d[i]  = data_q[i-1];
      end
      // Data still shifts on flush; only valid and ctrl are forced to a bubble.
      if (flush) begin
        valid_d = '0;
        ctrl_d  = '0;
      end
    end
  end

  always_comb begin
    kills = KillW'(valid_in);
    for (int i = 0; i < STAGES; i++) begin
      kills = kills + KillW'(valid_q[i]);
    end
    kill_sum = SumW'(kill_q) + SumW'(kills);
    kill_d   = kill_q;
    if (cnt_clr) begin
      kill_d = '0;
    end else if (flush) begin
      kill_d = (kill_sum > SumW'(CntMax)) ? CntMax : kill_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
      kill_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      kill_q  <= kill_d;
    end
  end

  assign valid_out = valid_q[STAGES-1];
  assign ctrl_out  = ctrl_q[STAGES-1];
  assign data_out  = data_q[STAGES-1];
  assign kill_cnt  = kill_q;

endmodule

// File: tb/tb_pipe_ctrl_stage_reg.sv
// Directed bench: a 1-slot and a 3-slot (3-bit counter) instance share one stimulus stream.
module tb_pipe_ctrl_stage_reg;

  logic        clk;
  logic        reset_n;
  logic        stall, flush, valid_in, cnt_clr;
  logic [3:0]  ctrl_in;
  logic [31:0] data_in;

  logic        a_valid, b_valid;
  logic [3:0]  a_ctrl, b_ctrl;
  logic [31:0] a_data, b_data;
  logic [7:0]  a_kill;
  logic [2:0]  b_kill;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_ctrl_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr), .valid_out(a_valid),
    .ctrl_out(a_ctrl), .data_out(a_data), .kill_cnt(a_kill)
  );

  pipe_ctrl_stage_reg #(.CTRL_W(4), .DATA_W(32), .STAGES(3), .CNT_W(3)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush), .valid_in(valid_in),
    .ctrl_in(ctrl_in), .data_in(data_in), .cnt_clr(cnt_clr), .valid_out(b_valid),
    .ctrl_out(b_ctrl), .data_out(b_data), .kill_cnt(b_kill)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        st, fl, vi, clr;
    logic [3:0]  c;
    logic [31:0] d;
    logic        av;
    logic [3:0]  ac;
    logic [31:0] ad;
    logic [7:0]  ak;
    logic        bv;
    logic [3:0]  bc;
    logic [31:0] bd;
    logic [7:0]  bk;
  } vec_t;

  localparam int NVec = 23;
  vec_t vecs [NVec];

  function automatic vec_t mk(logic st, logic fl, logic vi, logic clr, logic [3:0] c,
                              logic [31:0] d, logic av, logic [3:0] ac, logic [31:0] ad,
                              logic [7:0] ak, logic bv, logic [3:0] bc, logic [31:0] bd,
                              logic [7:0] bk);
    vec_t v;
    v.st = st; v.fl = fl; v.vi = vi; v.clr = clr; v.c = c; v.d = d;
    v.av = av; v.ac = ac; v.ad = ad; v.ak = ak;
    v.bv = bv; v.bc = bc; v.bd = bd; v.bk = bk;
    return v;
  endfunction

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", name, row, act, exp);
    end
  endtask

  task automatic check_all(input int row, input logic av, input logic [3:0] ac,
                           input logic [31:0] ad, input logic [7:0] ak, input logic bv,
                           input logic [3:0] bc, input logic [31:0] bd, input logic [7:0] bk);
    check("a_valid", row, 32'(a_valid), 32'(av));
    check("a_ctrl",  row, 32'(a_ctrl),  32'(ac));
    check("a_data",  row, a_data,       ad);
    check("a_kill",  row, 32'(a_kill),  32'(ak));
    check("b_valid", row, 32'(b_valid), 32'(bv));
    check("b_ctrl",  row, 32'(b_ctrl),  32'(bc));
    check("b_data",  row, b_data,       bd);
    check("b_kill",  row, 32'(b_kill),  32'(bk));
  endtask

  task automatic drive(input logic st, input logic fl, input logic vi, input logic clr,
                       input logic [3:0] c, input logic [31:0] d);
    stall = st; flush = fl; valid_in = vi; cnt_clr = clr; ctrl_in = c; data_in = d;
  endtask

  initial begin
    //             st fl vi clr c     d              av ac    ad             ak  bv bc    bd             bk
    vecs[0]  = mk(0, 0, 1, 0, 4'hB, 32'hDEADBEEF,  1, 4'hB, 32'hDEADBEEF,  0,  0, 4'h0, 32'h0,         0);
    vecs[1]  = mk(0, 0, 1, 0, 4'h1, 32'h1,         1, 4'h1, 32'h1,         0,  0, 4'h0, 32'h0,         0);
    vecs[2]  = mk(0, 0, 1, 0, 4'h2, 32'h2,         1, 4'h2, 32'h2,         0,  1, 4'hB, 32'hDEADBEEF,  0);
    vecs[3]  = mk(0, 0, 1, 0, 4'h3, 32'h3,         1, 4'h3, 32'h3,         0,  1, 4'h1, 32'h1,         0);
    vecs[4]  = mk(0, 0, 0, 0, 4'hF, 32'h4,         0, 4'h0, 32'h4,         0,  1, 4'h2, 32'h2,         0);
    vecs[5]  = mk(1, 0, 1, 0, 4'h5, 32'h5,         0, 4'h0, 32'h4,         0,  1, 4'h2, 32'h2,         0);
    vecs[6]  = mk(0, 0, 1, 0, 4'h6, 32'h6,         1, 4'h6, 32'h6,         0,  1, 4'h3, 32'h3,         0);
    vecs[7]  = mk(0, 0, 1, 0, 4'h7, 32'h7,         1, 4'h7, 32'h7,         0,  0, 4'h0, 32'h4,         0);
    vecs[8]  = mk(0, 0, 1, 0, 4'h8, 32'h8,         1, 4'h8, 32'h8,         0,  1, 4'h6, 32'h6,         0);
    vecs[9]  = mk(0, 1, 1, 0, 4'h9, 32'h9,         0, 4'h0, 32'h9,         2,  0, 4'h0, 32'h7,         4);
    vecs[10] = mk(0, 0, 1, 0, 4'hA, 32'hA,         1, 4'hA, 32'hA,         2,  0, 4'h0, 32'h8,         4);
    vecs[11] = mk(0, 0, 1, 0, 4'hC, 32'hC,         1, 4'hC, 32'hC,         2,  0, 4'h0, 32'h9,         4);
    vecs[12] = mk(1, 1, 0, 0, 4'hD, 32'hD,         0, 4'h0, 32'hD,         3,  0, 4'h0, 32'hA,         6);
    vecs[13] = mk(0, 0, 1, 0, 4'h1, 32'h11,        1, 4'h1, 32'h11,        3,  0, 4'h0, 32'hC,         6);
    vecs[14] = mk(0, 0, 1, 0, 4'h2, 32'h12,        1, 4'h2, 32'h12,        3,  0, 4'h0, 32'hD,         6);
    vecs[15] = mk(0, 0, 1, 0, 4'h3, 32'h13,        1, 4'h3, 32'h13,        3,  1, 4'h1, 32'h11,        6);
    vecs[16] = mk(0, 1, 0, 0, 4'h4, 32'h14,        0, 4'h0, 32'h14,        4,  0, 4'h0, 32'h12,        7);
    vecs[17] = mk(0, 1, 1, 0, 4'h5, 32'h15,        0, 4'h0, 32'h15,        5,  0, 4'h0, 32'h13,        7);
    vecs[18] = mk(0, 0, 1, 0, 4'h6, 32'h16,        1, 4'h6, 32'h16,        5,  0, 4'h0, 32'h14,        7);
    vecs[19] = mk(0, 1, 1, 1, 4'h7, 32'h17,        0, 4'h0, 32'h17,        0,  0, 4'h0, 32'h15,        0);
    vecs[20] = mk(0, 0, 1, 1, 4'h8, 32'h18,        1, 4'h8, 32'h18,        0,  0, 4'h0, 32'h16,        0);
    vecs[21] = mk(0, 1, 0, 0, 4'h9, 32'h19,        0, 4'h0, 32'h19,        1,  0, 4'h0, 32'h17,        1);
    vecs[22] = mk(1, 0, 1, 0, 4'hA, 32'h1A,        0, 4'h0, 32'h19,        1,  0, 4'h0, 32'h17,        1);

    reset_n = 1'b0;
    drive(0, 0, 0, 0, 4'h0, 32'h0);
    #12;
    check_all(-1, 0, 4'h0, 32'h0, 8'h0, 0, 4'h0, 32'h0, 8'h0);
    #1 reset_n = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      drive(vecs[i].st, vecs[i].fl, vecs[i].vi, vecs[i].clr, vecs[i].c, vecs[i].d);
      @(posedge clk);
      #1;
      check_all(i, vecs[i].av, vecs[i].ac, vecs[i].ad, vecs[i].ak,
                vecs[i].bv, vecs[i].bc, vecs[i].bd, vecs[i].bk);
    end

    // Fill every slot, then assert reset between edges and expect outputs to clear at once.
    drive(0, 0, 1, 0, 4'h3, 32'h33);
    repeat (3) @(posedge clk);
    #1;
    check_all(100, 1, 4'h3, 32'h33, 8'h1, 1, 4'h3, 32'h33, 8'h1);
    #3 reset_n = 1'b0;
    #1;
    check_all(101, 0, 4'h0, 32'h0, 8'h0, 0, 4'h0, 32'h0, 8'h0);
    drive(0, 0, 1, 0, 4'h5, 32'h55);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_all(102, 1, 4'h5, 32'h55, 8'h0, 0, 4'h0, 32'h0, 8'h0);
    @(posedge clk);
    #1;
    check_all(103, 1, 4'h5, 32'h55, 8'h0, 0, 4'h0, 32'h0, 8'h0);
    @(posedge clk);
    #1;
    check_all(104, 1, 4'h5, 32'h55, 8'h0, 1, 4'h5, 32'h55, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
